uart_responder: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_responder_byte_fifo.sv | 60 ++++++
 rtl/uart_responder.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART responder.
//   tx_state_t / rx_state_t : serial FSM states (idle, start bit, data bits, stop bit)
//   UART_DATA_BITS          : data bits per 8N1 frame
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_responder_byte_fifo.sv
// byte_fifo: first-word fall-through byte FIFO for received UART bytes.
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_data     : write request and byte; ignored when full unless a pop
//                         happens in the same cycle
//   pop                 : remove head entry; ignored when empty
//   pop_data            : current head byte (combinational)
//   empty, full         : occupancy status
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push_s = push & (~full | do_pop_s);
  assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= (AW+1)'(0);
      rd_ptr_r <= (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_responder.sv
// uart_responder: device-side end of the core's UART byte channel.
//   clk, reset                     : clock, asynchronous active-high reset
//   uart_in_data/valid, uart_in_ready    : core write request -> serial 8N1 on txd
//   uart_out_valid, uart_out_data/ready  : core read request <- RX byte FIFO
//   txd                            : serial transmit line, idle high
//   rxd                            : serial receive line (asynchronous)
//   rx_overflow                    : sticky, a received byte was dropped (FIFO full)
//   rx_frame_err                   : sticky, a stop bit was sampled low
module uart_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_in_data,
  input  logic       uart_in_valid,
  output logic       uart_in_ready,
  input  logic       uart_out_valid,
  output logic [7:0] uart_out_data,
  output logic       uart_out_ready,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overflow,
  output logic       rx_frame_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  // ---------------- TX ----------------
  tx_state_t                 tx_state_r, tx_state_next_s;
  logic [CW-1:0]             tx_cnt_r, tx_cnt_next_s;
  logic [2:0]                tx_bit_r, tx_bit_next_s;
  logic [UART_DATA_BITS-1:0] tx_shift_r, tx_shift_next_s;
  logic                      txd_r, txd_next_s;
  logic                      in_ready_r, in_ready_next_s;
  logic                      tx_armed_r, tx_armed_next_s;

  // TX next-state: the line level is precomputed so txd leaves a flop.
  always_comb begin
    tx_state_next_s = tx_state_r;
    tx_cnt_next_s   = tx_cnt_r;
    tx_bit_next_s   = tx_bit_r;
    tx_shift_next_s = tx_shift_r;
    txd_next_s      = txd_r;
    in_ready_next_s = 1'b0;
    // Re-arm only once the core has dropped valid after an accepted write.
    if (!uart_in_valid) begin
      tx_armed_next_s = 1'b1;
    end else begin
      tx_armed_next_s = tx_armed_r;
    end
    case (tx_state_r)
      TX_IDLE: begin
        txd_next_s = 1'b1;
        if (tx_armed_r && uart_in_valid) begin
          tx_shift_next_s = uart_in_data;
          tx_state_next_s = TX_START;
          tx_cnt_next_s   = CNT_ZERO;
          txd_next_s      = 1'b0;
          in_ready_next_s = 1'b1;
          tx_armed_next_s = 1'b0;
        end else begin
          tx_cnt_next_s = CNT_ZERO;
        end
      end
      TX_START: begin
        if (tx_cnt_r == CNT_LAST) begin
          tx_state_next_s = TX_DATA;
          tx_cnt_next_s   = CNT_ZERO;
          tx_bit_next_s   = 3'd0;
          txd_next_s      = tx_shift_r[0];
        end else begin
          tx_cnt_next_s = tx_cnt_r + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_next_s = CNT_ZERO;
          if (tx_bit_r == BIT_LAST) begin
            tx_state_next_s = TX_STOP;
            txd_next_s      = 1'b1;
          end else begin
            tx_bit_next_s   = tx_bit_r + 3'd1;
            tx_shift_next_s = {1'b0, tx_shift_r[UART_DATA_BITS-1:1]};
            txd_next_s      = tx_shift_r[1];
          end
        end else begin
          tx_cnt_next_s = tx_cnt_r + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == CNT_LAST) begin
          tx_state_next_s = TX_IDLE;
          tx_cnt_next_s   = CNT_ZERO;
        end else begin
          tx_cnt_next_s = tx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_next_s = TX_IDLE;
        tx_cnt_next_s   = CNT_ZERO;
        txd_next_s      = 1'b1;
      end
    endcase
  end

  // TX state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      txd_r      <= 1'b1;
      in_ready_r <= 1'b0;
      tx_armed_r <= 1'b1;
    end else begin
      tx_state_r <= tx_state_next_s;
      tx_cnt_r   <= tx_cnt_next_s;
      tx_bit_r   <= tx_bit_next_s;
      tx_shift_r <= tx_shift_next_s;
      txd_r      <= txd_next_s;
      in_ready_r <= in_ready_next_s;
      tx_armed_r <= tx_armed_next_s;
    end
  end

  // ---------------- RX ----------------
  logic                      rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t                 rx_state_r, rx_state_next_s;
  logic [CW-1:0]             rx_cnt_r, rx_cnt_next_s;
  logic [2:0]                rx_bit_r, rx_bit_next_s;
  logic [UART_DATA_BITS-1:0] rx_shift_r, rx_shift_next_s;
  logic                      rx_push_s, rx_ferr_s;
  logic                      overflow_r, frame_err_r;

  logic                      fifo_empty_s, fifo_full_s;
  logic [7:0]                fifo_head_s;
  logic                      pop_s;

  // RX next-state: all samples are taken at mid-bit relative to the start edge.
  always_comb begin
    rx_state_next_s = rx_state_r;
    rx_cnt_next_s   = rx_cnt_r;
    rx_bit_next_s   = rx_bit_r;
    rx_shift_next_s = rx_shift_r;
    rx_push_s       = 1'b0;
    rx_ferr_s       = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_next_s = RX_START;
          rx_cnt_next_s   = CNT_ZERO;
        end else begin
          rx_cnt_next_s = CNT_ZERO;
        end
      end
      RX_START: begin
        if (rx_cnt_r == CNT_HALF) begin
          rx_cnt_next_s = CNT_ZERO;
          // Line back high at mid start bit: a glitch, not a frame.
          if (rx_sync_r) begin
            rx_state_next_s = RX_IDLE;
          end else begin
            rx_state_next_s = RX_DATA;
            rx_bit_next_s   = 3'd0;
          end
        end else begin
          rx_cnt_next_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_next_s   = CNT_ZERO;
          rx_shift_next_s = {rx_sync_r, rx_shift_r[UART_DATA_BITS-1:1]};
          if (rx_bit_r == BIT_LAST) begin
            rx_state_next_s = RX_STOP;
          end else begin
            rx_bit_next_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_next_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == CNT_LAST) begin
          // Leave at the stop sample so the very next start edge is seen.
          rx_state_next_s = RX_IDLE;
          rx_cnt_next_s   = CNT_ZERO;
          if (rx_sync_r) begin
            rx_push_s = 1'b1;
          end else begin
            rx_ferr_s = 1'b1;
          end
        end else begin
          rx_cnt_next_s = rx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        rx_state_next_s = RX_IDLE;
        rx_cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // RX synchronizer, state register and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r   <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_prev_r   <= 1'b1;
      rx_state_r  <= RX_IDLE;
      rx_cnt_r    <= CNT_ZERO;
      rx_bit_r    <= 3'd0;
      rx_shift_r  <= 8'h00;
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_meta_r   <= rxd;
      rx_sync_r   <= rx_meta_r;
      rx_prev_r   <= rx_sync_r;
      rx_state_r  <= rx_state_next_s;
      rx_cnt_r    <= rx_cnt_next_s;
      rx_bit_r    <= rx_bit_next_s;
      rx_shift_r  <= rx_shift_next_s;
      overflow_r  <= overflow_r | (rx_push_s & fifo_full_s & ~pop_s);
      frame_err_r <= frame_err_r | rx_ferr_s;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push_s),
    .push_data (rx_shift_r),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // ---------------- Read path ----------------
  logic       out_armed_r;
  logic       out_ready_r;
  logic [7:0] out_data_r;

  assign pop_s = out_armed_r & uart_out_valid & ~fifo_empty_s;

  // Read handshake: pop, capture head and pulse ready together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_armed_r <= 1'b1;
      out_ready_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      out_ready_r <= pop_s;
      if (pop_s) begin
        out_data_r  <= fifo_head_s;
        out_armed_r <= 1'b0;
      end else if (!uart_out_valid) begin
        out_armed_r <= 1'b1;
      end
    end
  end

  assign txd            = txd_r;
  assign uart_in_ready  = in_ready_r;
  assign uart_out_ready = out_ready_r;
  assign uart_out_data  = out_data_r;
  assign rx_overflow    = overflow_r;
  assign rx_frame_err   = frame_err_r;

endmodule

// File: tb/tb_uart_responder.sv
// tb_uart_responder: randomized self-checking bench for uart_responder
// (CLKS_PER_BIT=4, FIFO_DEPTH=4) against a frame-level reference model.
module tb_uart_responder;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] uart_in_data = 8'h00;
  logic       uart_in_valid = 1'b0;
  logic       uart_in_ready;
  logic       uart_out_valid = 1'b0;
  logic [7:0] uart_out_data;
  logic       uart_out_ready;
  logic       txd;
  logic       rxd = 1'b1;
  logic       rx_overflow;
  logic       rx_frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] rd_q[$];   // bytes seen on the read channel
  logic [7:0] mq[$];     // model of FIFO contents
  logic       ovf_exp  = 1'b0;
  logic       ferr_exp = 1'b0;

  uart_responder #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uart_in_data   (uart_in_data),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ready  (uart_in_ready),
    .uart_out_valid (uart_out_valid),
    .uart_out_data  (uart_out_data),
    .uart_out_ready (uart_out_ready),
    .txd            (txd),
    .rxd            (rxd),
    .rx_overflow    (rx_overflow),
    .rx_frame_err   (rx_frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Capture every read-channel pulse.
  always @(negedge clk) begin
    if (!reset && uart_out_ready) rd_q.push_back(uart_out_data);
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected line level t cycles into an 8N1 frame of byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int k;
    k = t / CPB;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    uart_in_valid = 1'b0;
    uart_out_valid = 1'b0;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mq.delete();
    rd_q.delete();
    ovf_exp = 1'b0;
    ferr_exp = 1'b0;
    @(negedge clk);
  endtask

  // Single write with valid held for 'hold' cycles.
  task automatic tx_hold(input logic [7:0] b, input int hold);
    logic [127:0] ot, et, orr, er;
    ot = '0; et = '0; orr = '0; er = '0;
    @(negedge clk);
    uart_in_data = b;
    uart_in_valid = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      ot[i-1]  = txd;
      orr[i-1] = uart_in_ready;
      et[i-1]  = (i <= 10*CPB) ? frame_bit(b, i-1) : 1'b1;
      er[i-1]  = (i == 1);
      if (i == hold) uart_in_valid = 1'b0;
    end
    uart_in_valid = 1'b0;
    check_val("tx_ready", orr, er);
    check_val("tx_wave", ot, et);
  endtask

  // Second write issued 'delay' cycles into the first frame.
  task automatic tx_pair(input logic [7:0] b0, input logic [7:0] b1, input int delay);
    logic [127:0] ot, et, orr, er;
    ot = '0; et = '0; orr = '0; er = '0;
    @(negedge clk);
    uart_in_data = b0;
    uart_in_valid = 1'b1;
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      ot[i-1]  = txd;
      orr[i-1] = uart_in_ready;
      if (i <= 10*CPB) et[i-1] = frame_bit(b0, i-1);
      else if (i >= 10*CPB + 2 && i <= 20*CPB + 1) et[i-1] = frame_bit(b1, i - (10*CPB + 2));
      else et[i-1] = 1'b1;
      er[i-1] = (i == 1) || (i == 10*CPB + 2);
      if (uart_in_ready) uart_in_valid = 1'b0;
      if (i == 1 + delay) begin
        uart_in_data = b1;
        uart_in_valid = 1'b1;
      end
    end
    uart_in_valid = 1'b0;
    check_val("tx2_ready", orr, er);
    check_val("tx2_wave", ot, et);
  endtask

  // Model of one received frame.
  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (!stop) ferr_exp = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else ovf_exp = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic lvl;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) lvl = 1'b0;
      else if (k == 9) lvl = stop;
      else lvl = b[k-1];
      repeat (CPB) begin
        @(negedge clk);
        rxd = lvl;
      end
    end
    @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    model_rx(b, stop);
  endtask

  // Read request, optionally with a frame arriving while it is pending.
  task automatic do_read(input int budget, input logic send, input logic [7:0] sb,
                         output logic [7:0] d, output logic ok);
    int extra;
    d = 8'h00;
    ok = 1'b0;
    @(negedge clk);
    uart_out_valid = 1'b1;
    if (send) send_rx(sb, 1'b1);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_q.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    extra = rd_q.size();
    uart_out_valid = 1'b0;
    @(negedge clk);
    check_val("rd_pulses", 128'(extra), ok ? 128'd1 : 128'd0);
    if (rd_q.size() != 0) d = rd_q.pop_front();
    rd_q.delete();
  endtask

  task automatic read_check(input int budget, input logic send, input logic [7:0] sb);
    logic [7:0] d, ed;
    logic ok, eok;
    do_read(budget, send, sb, d, ok);
    eok = (mq.size() != 0);
    ed = 8'h00;
    if (eok) ed = mq.pop_front();
    check_val("rd_ok", 128'(ok), 128'(eok));
    if (eok && ok) check_val("rd_data", 128'(d), 128'(ed));
  endtask

  task automatic check_flags();
    check_val("rx_overflow", 128'(rx_overflow), 128'(ovf_exp));
    check_val("rx_frame_err", 128'(rx_frame_err), 128'(ferr_exp));
  endtask

  initial begin
    logic [7:0] b;
    // Reset values while reset is held.
    @(negedge clk);
    check_val("rst_txd", 128'(txd), 128'd1);
    check_val("rst_in_ready", 128'(uart_in_ready), 128'd0);
    check_val("rst_out_ready", 128'(uart_out_ready), 128'd0);
    check_val("rst_out_data", 128'(uart_out_data), 128'd0);
    check_flags();
    do_reset();

    // Transmit path.
    tx_hold(8'hA5, 20);
    tx_pair(8'h01, 8'hFF, int'($urandom_range(3, 30)));
    repeat (3) tx_hold(8'($urandom), int'($urandom_range(1, 30)));

    // Receive and read path.
    send_rx(8'h3C, 1'b1);
    read_check(20, 1'b0, 8'h00);
    read_check(20, 1'b1, 8'($urandom));
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        send_rx(b, 1'b1);
        read_check(20, 1'b0, 8'h00);
      end else begin
        read_check(20, 1'b1, b);
      end
    end
    check_flags();

    // Overflow: five frames into a four-entry FIFO.
    do_reset();
    for (int n = 0; n < 5; n++) send_rx(8'(8'h10 + n), 1'b1);
    check_flags();
    repeat (5) read_check(30, 1'b0, 8'h00);

    // Bad stop bit.
    do_reset();
    send_rx(8'h55, 1'b0);
    check_flags();
    read_check(20, 1'b0, 8'h00);

    // One-cycle low glitch.
    do_reset();
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_flags();
    read_check(20, 1'b0, 8'h00);

    // Reset in the middle of a transmitted data bit.
    do_reset();
    send_rx(8'($urandom_range(1, 255)), 1'b1);
    read_check(20, 1'b0, 8'h00);
    @(negedge clk);
    uart_in_data = 8'($urandom);
    uart_in_valid = 1'b1;
    @(negedge clk);
    uart_in_valid = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midrst_txd", 128'(txd), 128'd1);
    check_val("midrst_in_ready", 128'(uart_in_ready), 128'd0);
    check_val("midrst_out_ready", 128'(uart_out_ready), 128'd0);
    check_val("midrst_out_data", 128'(uart_out_data), 128'd0);
    check_val("midrst_ovf", 128'(rx_overflow), 128'd0);
    check_val("midrst_ferr", 128'(rx_frame_err), 128'd0);
    do_reset();
    tx_hold(8'($urandom), int'($urandom_range(1, 30)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
